// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the burst RAM responder.
// Imported by the array and the top-level FSM.
package burst_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ
    } state_t;

    localparam logic BR_CMD_READ   = 1'b0;
    localparam logic BR_CMD_WRITE  = 1'b1;
    localparam int   BR_DATA_WIDTH = 64;
    localparam int   BR_MASK_WIDTH = 8;

endpackage

// File: rtl/burst_ram_array.sv
// Single-port 64-bit word array with per-byte write enable and a registered read.
// Written so that FPGA tools map it onto block RAM.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int    DEPTH_BITWIDTH = 10,
    parameter string DATA_FILE      = ""
) (
    input  logic                      clk,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [BR_MASK_WIDTH-1:0]  we,
    input  logic [BR_DATA_WIDTH-1:0]  wdata,
    output logic [BR_DATA_WIDTH-1:0]  rdata
);

    logic [BR_DATA_WIDTH-1:0] mem [0:(2**DEPTH_BITWIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BR_MASK_WIDTH; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_ram.sv
// Burst RAM responder: accepts cache read/write commands and moves fixed-length
// 64-bit bursts in and out of an on-chip word array.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int    DEPTH_BITWIDTH = 10,
    parameter int    BURST_COUNT    = 4,
    parameter int    READ_LATENCY   = 3,
    parameter string DATA_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      br_cmd,
    input  logic                      br_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] br_addr,
    input  logic [BR_DATA_WIDTH-1:0]  br_wr_data,
    input  logic [BR_MASK_WIDTH-1:0]  br_data_mask,
    output logic [BR_DATA_WIDTH-1:0]  br_rd_data,
    output logic                      br_rd_data_valid,
    output logic                      busy,
    output logic                      cmd_err
);

    localparam int CNT_W = $clog2(READ_LATENCY + BURST_COUNT + 1);

    // cnt holds the number of cycles since the command cycle
    localparam logic [CNT_W-1:0] ISSUE_START = CNT_W'(READ_LATENCY - 2);
    localparam logic [CNT_W-1:0] ISSUE_END   = CNT_W'(READ_LATENCY - 2 + BURST_COUNT);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_LATENCY + BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST  = CNT_W'(BURST_COUNT - 1);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          offset;
    logic [DEPTH_BITWIDTH-1:0] base;
    logic [DEPTH_BITWIDTH-1:0] arr_addr;
    logic [BR_MASK_WIDTH-1:0]  arr_we;
    logic [BR_DATA_WIDTH-1:0]  arr_rdata;
    logic                      rd_issue;
    logic                      issue_d;

    // Array reads are issued two cycles before the beat is due: one cycle in the
    // array's read register, one in the output register.
    always_comb begin
        arr_addr = br_addr;
        arr_we   = '0;
        rd_issue = 1'b0;
        offset   = '0;
        case (state)
            IDLE: begin
                if (br_cmd_en) begin
                    if (br_cmd == BR_CMD_WRITE) begin
                        arr_we = ~br_data_mask;
                    end else begin
                        rd_issue = (READ_LATENCY == 2);
                    end
                end
            end
            WRITE: begin
                offset   = cnt;
                arr_addr = base + DEPTH_BITWIDTH'(offset);
                arr_we   = ~br_data_mask;
            end
            READ_WAIT, READ: begin
                offset   = cnt - ISSUE_START;
                arr_addr = base + DEPTH_BITWIDTH'(offset);
                rd_issue = (cnt >= ISSUE_START) && (cnt < ISSUE_END);
            end
            default: begin
                arr_addr = br_addr;
            end
        endcase
        if (rst) begin
            arr_we = '0;
        end
    end

    burst_ram_array #(
        .DEPTH_BITWIDTH(DEPTH_BITWIDTH),
        .DATA_FILE     (DATA_FILE)
    ) u_array (
        .clk  (clk),
        .addr (arr_addr),
        .we   (arr_we),
        .wdata(br_wr_data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            base             <= '0;
            busy             <= 1'b0;
            cmd_err          <= 1'b0;
            issue_d          <= 1'b0;
            br_rd_data       <= '0;
            br_rd_data_valid <= 1'b0;
        end else begin
            issue_d          <= rd_issue;
            br_rd_data_valid <= issue_d;
            br_rd_data       <= issue_d ? arr_rdata : '0;
            if (br_cmd_en && state != IDLE) begin
                cmd_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (br_cmd_en) begin
                        base <= br_addr;
                        cnt  <= CNT_W'(1);
                        if (br_cmd == BR_CMD_WRITE) begin
                            if (BURST_COUNT > 1) begin
                                state <= WRITE;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= READ_WAIT;
                            busy  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WRITE_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                READ_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WAIT_LAST) begin
                        state <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == READ_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: a per-cycle vector table followed by
// hand-written wrap, protocol-error and reset-mid-read sequences.
module tb_burst_ram;

    localparam int DB = 10;
    localparam int BC = 4;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_cmd;
    logic          br_cmd_en;
    logic [DB-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data;
    logic          br_rd_data_valid;
    logic          busy;
    logic          cmd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          en;
        logic          cmd;
        logic [DB-1:0] addr;
        logic [63:0]   wd;
        logic [7:0]    mask;
        logic          exp_valid;
        logic [63:0]   exp_data;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    burst_ram #(
        .DEPTH_BITWIDTH(DB),
        .BURST_COUNT   (BC),
        .READ_LATENCY  (RL),
        .DATA_FILE     ("")
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .busy            (busy),
        .cmd_err         (cmd_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_cmd_en    = 1'b0;
        br_cmd       = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic ev, input logic [63:0] ed, input logic eb);
        check_bit ({tag, " valid"}, br_rd_data_valid, ev);
        check_word({tag, " data"},  br_rd_data,       ed);
        check_bit ({tag, " busy"},  busy,             eb);
    endtask

    task automatic apply_stimulus(input vec_t v);
        br_cmd_en    = v.en;
        br_cmd       = v.cmd;
        br_addr      = v.addr;
        br_wr_data   = v.wd;
        br_data_mask = v.mask;
    endtask

    function automatic void add_vec(input logic en, input logic cmd, input logic [DB-1:0] addr,
                                    input logic [63:0] wd, input logic [7:0] mask,
                                    input logic ev, input logic [63:0] ed, input logic eb);
        vec_t v;
        v.en = en; v.cmd = cmd; v.addr = addr; v.wd = wd; v.mask = mask;
        v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic write_burst(input logic [DB-1:0] a, input logic [63:0] d [BC], input string tag);
        br_cmd_en = 1'b1; br_cmd = 1'b1; br_addr = a; br_wr_data = d[0]; br_data_mask = '0;
        check_bit({tag, " busy at cmd"}, busy, 1'b0);
        for (int j = 1; j < BC; j++) begin
            step();
            idle_inputs();
            br_wr_data = d[j];
            check_bit($sformatf("%s busy beat %0d", tag, j), busy, 1'b1);
        end
        step();
        idle_inputs();
        check_bit({tag, " busy after"}, busy, 1'b0);
    endtask

    // inject_at >= 1 pulses a stray write command that many cycles after the read command
    task automatic read_burst(input logic [DB-1:0] a, input logic [63:0] e [BC],
                              input int inject_at, input string tag);
        logic        ev;
        logic [63:0] ed;
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = a;
        check_bit({tag, " busy at cmd"}, busy, 1'b0);
        for (int j = 1; j <= RL + BC; j++) begin
            step();
            idle_inputs();
            if (j == inject_at) begin
                br_cmd_en = 1'b1; br_cmd = 1'b1; br_addr = a;
                br_wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            ev = (j >= RL) && (j < RL + BC);
            ed = ev ? e[j - RL] : 64'h0;
            check_output($sformatf("%s T+%0d", tag, j), ev, ed, j < RL + BC);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Write 0x010, back-to-back read, zero 0x020, masked write, read it back
        add_vec(1, 1, 10'h010, {16{4'h1}}, 8'h00, 0, 64'h0, 0);
        add_vec(0, 0, 10'h000, {16{4'h2}}, 8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, {16{4'h3}}, 8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, {16{4'h4}}, 8'h00, 0, 64'h0, 1);
        add_vec(1, 0, 10'h010, 64'h0,      8'h00, 0, 64'h0, 0);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, {16{4'h1}}, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, {16{4'h2}}, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, {16{4'h3}}, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, {16{4'h4}}, 1);
        add_vec(1, 1, 10'h020, 64'h0,      8'h00, 0, 64'h0, 0);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(1, 1, 10'h020, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, 0, 64'h0, 0);
        add_vec(0, 0, 10'h000, {16{4'hF}}, 8'hFF, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, {16{4'hF}}, 8'hFF, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, {16{4'hF}}, 8'hFF, 0, 64'h0, 1);
        add_vec(1, 0, 10'h020, 64'h0,      8'h00, 0, 64'h0, 0);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, 64'h0000_0000_BBBB_BBBB, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 1, 64'h0, 1);
        add_vec(0, 0, 10'h000, 64'h0,      8'h00, 0, 64'h0, 0);

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check_output("reset", 1'b0, 64'h0, 1'b0);
        check_bit("reset cmd_err", cmd_err, 1'b0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_busy);
            check_bit($sformatf("vec%0d cmd_err", i), cmd_err, 1'b0);
            step();
        end
        idle_inputs();

        // Burst crossing the top word wraps to word 0
        write_burst(10'h3FE, '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                               64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003}, "wrap wr");
        read_burst(10'h3FE, '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                              64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003}, -1, "wrap rd");

        // Stray write command during a read: ignored, but flagged stickily
        read_burst(10'h010, '{{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}}, 4, "err rd");
        check_bit("cmd_err set", cmd_err, 1'b1);
        read_burst(10'h010, '{{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}}, -1, "err reread");
        check_bit("cmd_err sticky", cmd_err, 1'b1);

        // Reset at the second valid beat of a read
        br_cmd_en = 1'b1; br_cmd = 1'b0; br_addr = 10'h010;
        step();
        idle_inputs();
        step();
        step();
        check_output("rstrd beat0", 1'b1, {16{4'h1}}, 1'b1);
        step();
        check_output("rstrd beat1", 1'b1, {16{4'h2}}, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rstrd after", 1'b0, 64'h0, 1'b0);
        check_bit("rstrd cmd_err", cmd_err, 1'b0);
        step();
        check_output("rstrd quiet", 1'b0, 64'h0, 1'b0);
        read_burst(10'h010, '{{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}}, -1, "post rst rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
